// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and data-bit count, used by
// both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS_N = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit timing counter: counts 0..clock_per_bit-1 and flags the last cycle
// of each bit period. restart_i holds the count at zero.
module uart_baud_cnt #(
    parameter int clock_per_bit = 13021
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int CNT_W = $clog2(clock_per_bit);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(clock_per_bit - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, LSB first, registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clock_per_bit = 13021
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       tx_ready,
    output logic       serial_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS_N - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        serial_q, serial_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        baud_restart;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Counter is parked at zero while idle so the start bit gets a full period.
    assign baud_restart = (state_q == IDLE);

    uart_baud_cnt #(
        .clock_per_bit(clock_per_bit)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .restart_i(baud_restart),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                if (data_valid) begin
                    state_d   = START_BIT;
                    serial_d  = 1'b0;
                    shreg_d   = data_in;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d   = DATA_BITS;
                    serial_d  = shreg_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY_BIT;
                        serial_d = parity_q;
`else
                        state_d  = STOP_BIT;
                        serial_d = 1'b1;
`endif
                    end else begin
                        // Shift right so the next bit to send is always at [0].
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        serial_d  = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_end) begin
                    state_d  = STOP_BIT;
                    serial_d = 1'b1;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = ~tx_ready;
    assign serial_tx = serial_q;
    assign tx_done   = done_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter clock_per_bit, default 13021, meaning clock cycles per serial bit (CLK/BAUD_RATE; 9600 baud default); legal range >= 2.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_in  input  8  byte to transmit, sampled on accept.
REQ-005 SHALL have port data_valid  input  1  request to send data_in.
REQ-006 SHALL have port tx_ready  output  1  high when a byte can be accepted.
REQ-007 SHALL have port serial_tx  output  1  serial line, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is on the line.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 SHALL implement FSM states IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only), STOP_BIT.
REQ-011 Accept SHALL occur on a rising edge where data_valid=1 and tx_ready=1; data_in latched into an internal shift register.
REQ-012 tx_ready SHALL be 1 only in IDLE; data_valid while tx_ready=0 SHALL be ignored, with no effect on the frame in flight.
REQ-013 On accept, state->START_BIT and serial_tx=0 from that edge (registered output, zero-cycle latency after the accept edge).
REQ-014 Each bit SHALL last exactly clock_per_bit cycles, timed by a counter 0..clock_per_bit-1.
REQ-015 DATA_BITS SHALL send 8 bits LSB first, bit index 0..7, then advance.
REQ-016 STOP_BIT SHALL drive serial_tx=1 for clock_per_bit cycles.
REQ-017 At the edge ending STOP_BIT: state->IDLE, tx_ready=1, tx_done=1 for exactly one cycle.
REQ-018 Back-to-back: data_valid held high SHALL start the next frame on the edge after tx_done, giving stop bit + 1 idle cycle between frames.
REQ-019 Frame length SHALL be 10*clock_per_bit cycles (11*clock_per_bit with parity).
REQ-020 tx_busy SHALL equal NOT tx_ready.
REQ-021 serial_tx SHALL be glitch-free (driven from a flop) and 1 in IDLE.
REQ-022 Unreachable state encodings SHALL return to IDLE next edge with serial_tx=1.

Reset
REQ-023 rst=1 at a rising edge SHALL force: state IDLE, serial_tx=1, tx_ready=1, tx_busy=0, tx_done=0, counters and bit index 0.
REQ-024 rst mid-frame SHALL abort the frame immediately; no tx_done pulse; line high from that edge.
REQ-025 rst and data_valid at the same edge: rst wins, byte not accepted.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY_BIT state inserted between DATA_BITS and STOP_BIT, sending even parity (XOR of the 8 data bits) for clock_per_bit cycles.
REQ-027 Macro undefined: no parity logic; DATA_BITS goes directly to STOP_BIT (8N1).

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state encoding constants and DATA_BITS_N=8, shared with the receiver.
REQ-029 Sub-module uart_baud_cnt SHALL provide the per-bit counter with a restart input and a bit_end pulse at count clock_per_bit-1.

Verification (clock_per_bit=4 unless stated)
REQ-030 Send 0x55 after reset -> serial_tx: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; tx_done one pulse at cycle 40.
REQ-031 data_valid held high with 0xA5 then 0x3C -> two frames, exactly one idle-high cycle between them, tx_ready low for 40 cycles each.
REQ-032 Pulse data_valid with 0xFF during the DATA_BITS of a frame carrying 0x00 -> the line carries only 0x00; 0xFF never appears.
REQ-033 rst asserted at cycle 15 of a frame -> serial_tx=1, tx_ready=1 at next edge; no tx_done; a new 0x81 sent afterwards is correct.
REQ-034 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 44 cycles; send 0x03 -> parity bit 0.
REQ-035 Loopback to the receiver at default clock_per_bit=13021 with bytes 0x00, 0xFF, 0x5A -> received bytes match, data_ready once per byte.
